// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//   Shared types and helpers for the sequential binary-to-BCD converter.
//   - bcd_state_t : converter FSM states
//   - BCD_DIGIT_W : width of one BCD digit
//   - min_digits  : smallest number of decimal digits able to hold 2**n_bits-1
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } bcd_state_t;

  // Number of decimal digits needed for the largest n_bits-wide unsigned value.
  // Valid for n_bits up to 63; 10**19 already exceeds 2**63-1.
  function automatic int min_digits(input int n_bits);
    longint unsigned max_v;
    longint unsigned pow_v;
    int              d;
    max_v = (64'd1 << n_bits) - 64'd1;
    pow_v = 64'd1;
    d     = 32'sd0;
    for (int i = 0; i < 19; i++) begin
      if (pow_v <= max_v) begin
        pow_v = pow_v * 64'd10;
        d     = d + 32'sd1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
//   Double-dabble digit correction: a digit of 5 or more gets +3 so that the
//   following left shift carries correctly into the next decimal digit.
//   Ports:
//     d  in   4  BCD digit before correction (0..9 in normal operation)
//     q  out  4  corrected digit
// ---------------------------------------------------------------------------
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  // Add-3 correction; d<=9 keeps the 4-bit sum in range.
  always_comb begin
    q = d;
    if (d >= 4'd5) begin
      q = d + 4'd3;
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/bcd_seq_conv.sv
// ---------------------------------------------------------------------------
// bcd_seq_conv
//   Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
//   clock behind a start/busy/done handshake, with a leading-zero blanking mask
//   for the seven-segment scan logic.
//   Parameters:
//     N_BITS    width of the unsigned binary operand (>=1)
//     N_DIGITS  number of BCD output digits (must cover 2**N_BITS-1)
//   Ports:
//     clk    in   1           rising-edge clock
//     rst    in   1           asynchronous active-high reset
//     start  in   1           conversion request, honoured only when not busy
//     in     in   N_BITS      operand, captured on the accepting edge
//     busy   out  1           conversion in progress
//     done   out  1           one-cycle pulse: bcd/lz hold a new result
//     bcd    out  4*N_DIGITS  result, digit 0 (ones) in bcd[3:0]
//     lz     out  N_DIGITS    lz[i]=1 when digit i and all higher digits are 0
// ---------------------------------------------------------------------------
module bcd_seq_conv
  import bcd_pkg::*;
#(
  parameter int N_BITS   = 11,
  parameter int N_DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [N_BITS-1:0]               in,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*N_DIGITS-1:0] bcd,
  output logic [N_DIGITS-1:0]             lz
);

  localparam int                   BCD_W    = BCD_DIGIT_W * N_DIGITS;
  localparam int                   CNT_W    = $clog2(N_BITS + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N_BITS - 1);
  localparam logic [N_DIGITS-1:0]  LZ_RESET = ~(N_DIGITS'(1'b1));

  generate
    if (N_BITS < 1) begin : g_bad_bits
      $error("bcd_seq_conv: N_BITS must be at least 1");
    end
    if (N_DIGITS < min_digits(N_BITS)) begin : g_bad_digits
      $error("bcd_seq_conv: N_DIGITS too small to hold 2**N_BITS-1");
    end
  endgenerate

  bcd_state_t                 state_r;
  bcd_state_t                 state_nxt_s;
  logic                       accept_s;
  logic                       finish_s;
  logic [CNT_W-1:0]           cnt_r;
  logic [N_BITS-1:0]          bin_sr_r;
  logic [BCD_W-1:0]           dig_sr_r;
  logic [BCD_W-1:0]           adj_s;
  logic [BCD_W+N_BITS-1:0]    shift_s;
  logic [BCD_W-1:0]           dig_nxt_s;
  logic [N_BITS-1:0]          bin_nxt_s;
  logic [N_DIGITS-1:0]        lz_nxt_s;
  logic                       hi_zero_s;
  logic                       busy_r;
  logic                       done_r;
  logic [BCD_W-1:0]           bcd_r;
  logic [N_DIGITS-1:0]        lz_r;

  // Per-digit add-3 correction applied to the whole scratch register at once.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (dig_sr_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The corrected digits and the operand shift as one register; the operand
  // MSB lands in the LSB of digit 0 and the corrected top bit falls off.
  assign shift_s   = {adj_s, bin_sr_r} << 1'b1;
  assign dig_nxt_s = shift_s[BCD_W+N_BITS-1 -: BCD_W];
  assign bin_nxt_s = shift_s[N_BITS-1:0];

  // Leading-zero mask of the value about to be published; digit 0 is never
  // blanked so a zero result still shows a single 0.
  always_comb begin
    lz_nxt_s  = {N_DIGITS{1'b0}};
    hi_zero_s = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      hi_zero_s   = hi_zero_s & (dig_nxt_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      lz_nxt_s[i] = hi_zero_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and accept/finish strobes; start is ignored while converting.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = CONVERT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CONVERT: begin
        if (cnt_r == CNT_LAST) begin
          finish_s    = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CONVERT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Scratch registers: load on accept, one shift per CONVERT edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr_r <= {N_BITS{1'b0}};
      dig_sr_r <= {BCD_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      bin_sr_r <= in;
      dig_sr_r <= {BCD_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (state_r == CONVERT) begin
      bin_sr_r <= bin_nxt_s;
      dig_sr_r <= dig_nxt_s;
      cnt_r    <= cnt_r + CNT_W'(1'b1);
    end
  end

  // Output registers; bcd/lz only move on the final shift edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      bcd_r  <= {BCD_W{1'b0}};
      lz_r   <= LZ_RESET;
    end else begin
      busy_r <= (state_nxt_s == CONVERT);
      done_r <= finish_s;
      if (finish_s) begin
        bcd_r <= dig_nxt_s;
        lz_r  <= lz_nxt_s;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = bcd_r;
  assign lz   = lz_r;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// ---------------------------------------------------------------------------
// tb_bcd_seq_conv
//   Self-checking bench for bcd_seq_conv (11-bit/4-digit instance plus a
//   16-bit/5-digit instance). A transaction-level model predicts busy, done,
//   bcd and lz every cycle; directed checks pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_bcd_seq_conv;

  localparam int NB = 11;
  localparam int ND = 4;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic [10:0] in_v  = 11'd0;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  lz;

  logic        start16 = 1'b0;
  logic [15:0] in16    = 16'd0;
  logic        busy16;
  logic        done16;
  logic [19:0] bcd16;
  logic [4:0]  lz16;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bcd_seq_conv #(.N_BITS(NB), .N_DIGITS(ND)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in(in_v),
    .busy(busy), .done(done), .bcd(bcd), .lz(lz)
  );

  bcd_seq_conv #(.N_BITS(16), .N_DIGITS(5)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .in(in16),
    .busy(busy16), .done(done16), .bcd(bcd16), .lz(lz16)
  );

  always #5 clk = ~clk;

  // Reference result: decimal digits by division.
  function automatic logic [15:0] ref_bcd(input int v);
    int          t;
    logic [15:0] r;
    t = v;
    r = 16'h0000;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference blanking: digit i (i>=1) is blank when the value is below 10**i.
  function automatic logic [3:0] ref_lz(input int v);
    logic [3:0] r;
    int         p;
    r = 4'b0000;
    p = 1;
    for (int i = 1; i < ND; i++) begin
      p    = p * 10;
      r[i] = (v < p);
    end
    return r;
  endfunction

  // Transaction model: an accepted request completes NB edges later.
  bit          m_pending = 1'b0;
  int          m_cnt     = 0;
  int          m_op      = 0;
  logic        m_done    = 1'b0;
  logic [15:0] m_bcd     = 16'h0000;
  logic [3:0]  m_lz      = 4'b1110;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending <= 1'b0;
      m_cnt     <= 0;
      m_done    <= 1'b0;
      m_bcd     <= 16'h0000;
      m_lz      <= 4'b1110;
    end else begin
      m_done <= 1'b0;
      if (m_pending) begin
        if (m_cnt == 1) begin
          m_pending <= 1'b0;
          m_done    <= 1'b1;
          m_bcd     <= ref_bcd(m_op);
          m_lz      <= ref_lz(m_op);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (start) begin
        m_pending <= 1'b1;
        m_cnt     <= NB;
        m_op      <= int'(in_v);
      end
    end
  end

  // Cycle compare of the 11-bit instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (busy !== m_pending || done !== m_done || bcd !== m_bcd || lz !== m_lz) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t got busy=%b done=%b bcd=%h lz=%b expected busy=%b done=%b bcd=%h lz=%b",
                 $time, busy, done, bcd, lz, m_pending, m_done, m_bcd, m_lz);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_conv(input int v);
    @(posedge clk);
    #1;
    start = 1'b1;
    in_v  = v[10:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    in_v  = 11'h5A5;
  endtask

  // Returns at the negedge where done is seen; lat counts edges after accept.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i - 1;
        break;
      end
    end
    if (lat < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_done: got no done within 40 cycles expected done");
    end
  endtask

  task automatic run16(input int v, input logic [19:0] exp_bcd, input logic [4:0] exp_lz);
    int lat;
    @(posedge clk);
    #1;
    start16 = 1'b1;
    in16    = v[15:0];
    @(posedge clk);
    #1;
    start16 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done16 === 1'b1) begin
        lat = i - 1;
        break;
      end
    end
    check("w16_latency", lat, 32'd16);
    check("w16_bcd", bcd16, exp_bcd);
    check("w16_lz", lz16, exp_lz);
    @(negedge clk);
    check("w16_done_width", done16, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;

    // Reset held 3 clocks.
    #2;
    rst    = 1'b1;
    #1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bcd", bcd, 16'h0000);
    check("rst_lz", lz, 4'b1110);

    // Directed values with hand-computed results.
    start_conv(2047);
    wait_done(lat);
    check("max_latency", lat, 32'd11);
    check("max_bcd", bcd, 16'h2047);
    check("max_lz", lz, 4'b0000);

    start_conv(0);
    wait_done(lat);
    check("zero_bcd", bcd, 16'h0000);
    check("zero_lz", lz, 4'b1110);

    start_conv(57);
    wait_done(lat);
    check("v57_bcd", bcd, 16'h0057);
    check("v57_lz", lz, 4'b1100);
    @(negedge clk);
    check("hold_idle_bcd", bcd, 16'h0057);

    // start during busy is ignored; start during DONE is accepted.
    start_conv(1234);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    in_v  = 11'd999;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("ignore_bcd", bcd, 16'h1234);
    start = 1'b1;
    in_v  = 11'd999;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("b2b_latency", lat, 32'd11);
    check("b2b_bcd", bcd, 16'h0999);
    check("b2b_lz", lz, 4'b1000);

    // Reset mid-conversion discards the partial result.
    start_conv(1500);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_bcd", bcd, 16'h0000);
    check("midrst_lz", lz, 4'b1110);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    start_conv(42);
    wait_done(lat);
    check("after_rst_bcd", bcd, 16'h0042);
    check("after_rst_lz", lz, 4'b1100);

    // Full operand range; the cycle compare checks values and done width.
    for (int v = 0; v < 2048; v++) begin
      start_conv(v);
      wait_done(lat);
      check("sweep_latency", lat, 32'd11);
    end

    // Wider instance.
    run16(65535, 20'h65535, 5'b00000);
    run16(100, 20'h00100, 5'b11000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
